// File: rtl/pin_physics_if.sv
// Collision-to-physics bundle: rack load and collision results in, committed pin snapshot out.
// Pure wiring, no latency; no backpressure, since the producer pulses and the physics side drops work while busy.
interface pin_physics_if #(
    parameter int NUM_PINS = 10
);
    logic                      rack_load_in;
    logic [NUM_PINS-1:0][10:0] rack_x_in;
    logic [NUM_PINS-1:0][9:0]  rack_y_in;
    logic                      coll_valid_in;
    logic [NUM_PINS-1:0][15:0] coll_vx_in;
    logic [NUM_PINS-1:0][15:0] coll_vy_in;
    logic [NUM_PINS-1:0]       coll_hit_in;

    logic [NUM_PINS-1:0][10:0] pins_x_out;
    logic [NUM_PINS-1:0][9:0]  pins_y_out;
    logic [NUM_PINS-1:0][15:0] pins_vx_out;
    logic [NUM_PINS-1:0][15:0] pins_vy_out;
    logic [NUM_PINS-1:0]       pins_down_out;
    logic                      valid_out;
    logic                      busy_out;
    logic                      all_still_out;
    logic                      overrun_out;

    modport master (
        output rack_load_in, rack_x_in, rack_y_in,
        output coll_valid_in, coll_vx_in, coll_vy_in, coll_hit_in,
        input  pins_x_out, pins_y_out, pins_vx_out, pins_vy_out, pins_down_out,
        input  valid_out, busy_out, all_still_out, overrun_out
    );

    modport slave (
        input  rack_load_in, rack_x_in, rack_y_in,
        input  coll_valid_in, coll_vx_in, coll_vy_in, coll_hit_in,
        output pins_x_out, pins_y_out, pins_vx_out, pins_vy_out, pins_down_out,
        output valid_out, busy_out, all_still_out, overrun_out
    );
endinterface

// File: rtl/pin_physics.sv
// Pin integrator: friction + position update, one pin per cycle; snapshot valid 11 cycles after coll_valid_in, 1 after rack load.
// No backpressure: collision results arriving while busy are dropped and flagged on the sticky overrun output.
module pin_physics #(
    parameter int NUM_PINS       = 10,
    parameter int FRAC_BITS      = 4,
    parameter int FRICTION_SHIFT = 5,
    parameter int SCREEN_WIDTH   = 1024,
    parameter int SCREEN_HEIGHT  = 768
) (
    input  logic         clk_in,
    input  logic         rst_in,
    pin_physics_if.slave bus
);
    localparam int PXW  = 11 + FRAC_BITS;
    localparam int PYW  = 10 + FRAC_BITS;
    localparam int IDXW = $clog2(NUM_PINS);

    localparam logic signed [16:0] X_LIM  = 17'(SCREEN_WIDTH << FRAC_BITS);
    localparam logic signed [16:0] Y_LIM  = 17'(SCREEN_HEIGHT << FRAC_BITS);
    localparam logic [PXW-1:0]     X_PARK = PXW'(SCREEN_WIDTH << FRAC_BITS);
    localparam logic [PYW-1:0]     Y_PARK = PYW'(SCREEN_HEIGHT << FRAC_BITS);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

    state_t                    state_q;
    logic [IDXW-1:0]           idx_q;
    logic [NUM_PINS-1:0][PXW-1:0] px_q, px_d;
    logic [NUM_PINS-1:0][PYW-1:0] py_q, py_d;
    logic [NUM_PINS-1:0][15:0] vx_q, vx_d, vy_q, vy_d;
    logic [NUM_PINS-1:0]       down_q, down_d;
    logic [NUM_PINS-1:0][15:0] cap_vx_q, cap_vy_q;
    logic [NUM_PINS-1:0]       cap_hit_q;

    logic [NUM_PINS-1:0][10:0] x_out_q;
    logic [NUM_PINS-1:0][9:0]  y_out_q;
    logic [NUM_PINS-1:0][15:0] vx_out_q, vy_out_q;
    logic [NUM_PINS-1:0]       down_out_q;
    logic                      valid_q, still_q, overrun_q;

    logic [15:0]       vx_sel, vy_sel, vx_new, vy_new;
    logic signed [16:0] nx, ny;
    logic              retire, still_d;

    // Sign-magnitude decay; -32768 is folded to -32767 so the magnitude fits 15 bits.
    function automatic logic [15:0] friction(input logic [15:0] v);
        logic [15:0] vc, mag, dec, rem;
        vc  = (v == 16'h8000) ? 16'h8001 : v;
        mag = vc[15] ? (~vc + 16'd1) : vc;
        dec = mag >> FRICTION_SHIFT;
        if (dec == 16'd0) dec = 16'd1;
        rem = (mag > dec) ? (mag - dec) : 16'd0;
        friction = vc[15] ? (~rem + 16'd1) : rem;
    endfunction

    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        down_d = down_q;
        vx_sel = cap_hit_q[idx_q] ? cap_vx_q[idx_q] : vx_q[idx_q];
        vy_sel = cap_hit_q[idx_q] ? cap_vy_q[idx_q] : vy_q[idx_q];
        vx_new = friction(vx_sel);
        vy_new = friction(vy_sel);
        nx     = $signed(17'(px_q[idx_q])) + $signed({vx_new[15], vx_new});
        ny     = $signed(17'(py_q[idx_q])) + $signed({vy_new[15], vy_new});
        retire = nx[16] | ny[16] | (nx >= X_LIM) | (ny >= Y_LIM);
        if (state_q == S_UPDATE && !down_q[idx_q]) begin
            if (retire) begin
                down_d[idx_q] = 1'b1;
                px_d[idx_q]   = X_PARK;
                py_d[idx_q]   = Y_PARK;
                vx_d[idx_q]   = '0;
                vy_d[idx_q]   = '0;
            end else begin
                px_d[idx_q]   = nx[PXW-1:0];
                py_d[idx_q]   = ny[PYW-1:0];
                vx_d[idx_q]   = vx_new;
                vy_d[idx_q]   = vy_new;
            end
        end
        still_d = 1'b1;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (vx_d[i] != '0 || vy_d[i] != '0) still_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
            vx_q       <= '0;
            vy_q       <= '0;
            down_q     <= '0;
            cap_vx_q   <= '0;
            cap_vy_q   <= '0;
            cap_hit_q  <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            vx_out_q   <= '0;
            vy_out_q   <= '0;
            down_out_q <= '1;
            valid_q    <= 1'b0;
            still_q    <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.rack_load_in) begin
                // Load wins over everything and aborts any pass in flight.
                for (int i = 0; i < NUM_PINS; i++) begin
                    px_q[i] <= {bus.rack_x_in[i], {FRAC_BITS{1'b0}}};
                    py_q[i] <= {bus.rack_y_in[i], {FRAC_BITS{1'b0}}};
                end
                vx_q       <= '0;
                vy_q       <= '0;
                down_q     <= '0;
                x_out_q    <= bus.rack_x_in;
                y_out_q    <= bus.rack_y_in;
                vx_out_q   <= '0;
                vy_out_q   <= '0;
                down_out_q <= '0;
                valid_q    <= 1'b1;
                still_q    <= 1'b1;
                overrun_q  <= 1'b0;
                idx_q      <= '0;
                state_q    <= S_IDLE;
            end else begin
                if (bus.coll_valid_in && state_q != S_IDLE) overrun_q <= 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (bus.coll_valid_in) begin
                            cap_vx_q  <= bus.coll_vx_in;
                            cap_vy_q  <= bus.coll_vy_in;
                            cap_hit_q <= bus.coll_hit_in;
                            idx_q     <= '0;
                            state_q   <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        px_q   <= px_d;
                        py_q   <= py_d;
                        vx_q   <= vx_d;
                        vy_q   <= vy_d;
                        down_q <= down_d;
                        if (idx_q == IDXW'(NUM_PINS - 1)) begin
                            // Commit from next-state so the last pin lands in the same snapshot.
                            for (int i = 0; i < NUM_PINS; i++) begin
                                x_out_q[i] <= px_d[i][PXW-1:FRAC_BITS];
                                y_out_q[i] <= py_d[i][PYW-1:FRAC_BITS];
                            end
                            vx_out_q   <= vx_d;
                            vy_out_q   <= vy_d;
                            down_out_q <= down_d;
                            still_q    <= still_d;
                            valid_q    <= 1'b1;
                            state_q    <= S_COMMIT;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                    S_COMMIT: state_q <= S_IDLE;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pins_x_out    = x_out_q;
    assign bus.pins_y_out    = y_out_q;
    assign bus.pins_vx_out   = vx_out_q;
    assign bus.pins_vy_out   = vy_out_q;
    assign bus.pins_down_out = down_out_q;
    assign bus.valid_out     = valid_q;
    assign bus.busy_out      = (state_q != S_IDLE);
    assign bus.all_still_out = still_q;
    assign bus.overrun_out   = overrun_q;
endmodule
